// File: rtl/ysyx_25040129_csr_trap.sv
// rtl/ysyx_25040129_csr_trap.sv - machine-mode CSR file with trap entry, mret return and 64-bit counters
//
// Purpose:
//   Zicsr read-modify-write access from execute, trap entry / mret from
//   write-back, and a registered PC redirect back to fetch.
//
// Optional feature:
//   YSYX_25040129_CSR_COUNTER_EN - when defined, mcycle/minstret (plus the
//   mcycleh/minstreth halves for XLEN=32) are real 64-bit counters. When
//   undefined the counter addresses stay legal but read 0 and ignore writes.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   csr_op/addr/wdata         00 none, 01 write, 10 set, 11 clear
//   csr_rdata, csr_illegal    combinational old value / illegal-access flag
//   trap_valid/cause/pc       trap entry pulse with mcause and faulting PC
//   mret                      mret retire pulse
//   retire                    one instruction retired this cycle
//   redirect_valid/pc         registered one-cycle fetch redirect
//   mstatus_mie               current global interrupt enable
module ysyx_25040129_csr_trap #(
  parameter int              XLEN      = 32,
  parameter logic [31:0]     VENDOR_ID = 32'h79737978,
  parameter logic [31:0]     ARCH_ID   = 32'd25040129,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // MXL field: 1 for RV32, 2 for RV64; extension bits I (8) and M (12).
  localparam logic [1:0]      MISA_MXL = (XLEN == 64) ? 2'b10 : 2'b01;
  localparam logic [XLEN-1:0] MISA_VAL = {MISA_MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h0000_1100);

  // Architectural state. MPP is hard-wired to machine mode so it has no flop.
  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;

  // Counter read views, XLEN wide; the high halves only matter for XLEN=32.
  logic [XLEN-1:0] cyc_lo;
  logic [XLEN-1:0] cyc_hi;
  logic [XLEN-1:0] ins_lo;
  logic [XLEN-1:0] ins_hi;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] rd_val;
  logic            rd_impl;
  logic [XLEN-1:0] wr_val;
  logic            csr_wr;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_target;

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie_q;
    mstatus_val[3]     = mie_q;
  end

  // Read decode. rd_impl marks addresses that exist for legality purposes;
  // counter addresses count as implemented even when the counters are not built.
  always_comb begin
    rd_val  = '0;
    rd_impl = 1'b0;
    case (csr_addr)
      A_MSTATUS:   begin rd_impl = 1'b1; rd_val = mstatus_val;          end
      A_MISA:      begin rd_impl = 1'b1; rd_val = MISA_VAL;             end
      A_MTVEC:     begin rd_impl = 1'b1; rd_val = mtvec_q;              end
      A_MSCRATCH:  begin rd_impl = 1'b1; rd_val = mscratch_q;           end
      A_MEPC:      begin rd_impl = 1'b1; rd_val = mepc_q;               end
      A_MCAUSE:    begin rd_impl = 1'b1; rd_val = mcause_q;             end
      A_MCYCLE:    begin rd_impl = 1'b1; rd_val = cyc_lo;               end
      A_MINSTRET:  begin rd_impl = 1'b1; rd_val = ins_lo;               end
      A_MCYCLEH: begin
        if (XLEN == 32) begin
          rd_impl = 1'b1;
          rd_val  = cyc_hi;
        end
      end
      A_MINSTRETH: begin
        if (XLEN == 32) begin
          rd_impl = 1'b1;
          rd_val  = ins_hi;
        end
      end
      A_MVENDORID: begin rd_impl = 1'b1; rd_val = XLEN'(VENDOR_ID);     end
      A_MARCHID:   begin rd_impl = 1'b1; rd_val = XLEN'(ARCH_ID);       end
      A_MIMPID:    begin rd_impl = 1'b1; rd_val = '0;                   end
      A_MHARTID:   begin rd_impl = 1'b1; rd_val = '0;                   end
      default:     begin rd_impl = 1'b0; rd_val = '0;                   end
    endcase
  end

  assign csr_rdata   = rd_val;
  assign csr_illegal = (csr_op != OP_NONE) && (!rd_impl || (csr_addr[11:10] == 2'b11));

  always_comb begin
    case (csr_op)
      OP_WRITE: wr_val = csr_wdata;
      OP_SET:   wr_val = rd_val | csr_wdata;
      OP_CLEAR: wr_val = rd_val & ~csr_wdata;
      default:  wr_val = rd_val;
    endcase
  end

  // Trap and mret both outrank a CSR access issued in the same cycle.
  assign csr_wr = (csr_op != OP_NONE) && !csr_illegal && !trap_valid && !mret;

  // Vectored interrupts land at base + 4*cause; shifting the cause left by
  // two drops the interrupt flag and gives the XLEN-truncated offset.
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  always_comb begin
    if (mtvec_q[0] && trap_cause[XLEN-1])
      trap_target = mtvec_base + {trap_cause[XLEN-3:0], 2'b00};
    else
      trap_target = mtvec_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RST[XLEN-1:2], 1'b0, MTVEC_RST[0]};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= XLEN'(11);
    end else if (trap_valid) begin
      mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
      mcause_q <= trap_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_q  <= wr_val[3];
          mpie_q <= wr_val[7];
        end
        A_MTVEC:    mtvec_q    <= {wr_val[XLEN-1:2], 1'b0, wr_val[0]};
        A_MSCRATCH: mscratch_q <= wr_val;
        A_MEPC:     mepc_q     <= {wr_val[XLEN-1:2], 2'b00};
        A_MCAUSE:   mcause_q   <= wr_val;
        default: ;
      endcase
    end
  end

  // Redirect uses pre-edge mtvec/mepc; reset in the same cycle suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= trap_valid | mret;
      if (trap_valid)
        redirect_pc <= trap_target;
      else if (mret)
        redirect_pc <= mepc_q;
    end
  end

  assign mstatus_mie = mie_q;

`ifdef YSYX_25040129_CSR_COUNTER_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
  logic [63:0] mcycle_d;
  logic [63:0] minstret_d;

  assign cyc_lo = mcycle_q[XLEN-1:0];
  assign ins_lo = minstret_q[XLEN-1:0];
  assign cyc_hi = XLEN'(mcycle_q >> 32);
  assign ins_hi = XLEN'(minstret_q >> 32);

  // A software write replaces only the addressed half; the untouched half
  // holds, so no increment or carry happens for that counter in that cycle.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + (retire ? 64'd1 : 64'd0);
    if (csr_wr) begin
      case (csr_addr)
        A_MCYCLE:
          mcycle_d = (XLEN == 32) ? {mcycle_q[63:32], wr_val[31:0]} : 64'(wr_val);
        A_MINSTRET:
          minstret_d = (XLEN == 32) ? {minstret_q[63:32], wr_val[31:0]} : 64'(wr_val);
        A_MCYCLEH:
          if (XLEN == 32) mcycle_d = {wr_val[31:0], mcycle_q[31:0]};
        A_MINSTRETH:
          if (XLEN == 32) minstret_d = {wr_val[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_retire;

  assign cyc_lo        = '0;
  assign cyc_hi        = '0;
  assign ins_lo        = '0;
  assign ins_hi        = '0;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_ysyx_25040129_csr_trap.sv
// tb/tb_ysyx_25040129_csr_trap.sv - scoreboard bench for the CSR/trap block
module tb_ysyx_25040129_csr_trap;
  localparam int XLEN = 32;
`ifdef YSYX_25040129_CSR_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret;
  logic            retire;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mstatus_mie;

  always #5 clk = ~clk;

  ysyx_25040129_csr_trap #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret(mret), .retire(retire),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mstatus_mie(mstatus_mie)
  );

  // Reference model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;

  typedef struct { int tag; logic [31:0] rdata; logic illegal; logic mie; } rd_item_t;
  typedef struct { int due; logic [31:0] pc; } redir_item_t;
  rd_item_t    rd_q[$];
  redir_item_t redir_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc - 1);
    end
  endtask

  function automatic void model_read(input logic [11:0] a, output logic [31:0] v, output bit impl);
    impl = 1;
    v    = 0;
    if (a == 12'h300)      v = 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
    else if (a == 12'h301) v = (32'd1 << 30) + (32'd1 << 12) + (32'd1 << 8);
    else if (a == 12'h305) v = m_mtvec;
    else if (a == 12'h340) v = m_mscratch;
    else if (a == 12'h341) v = m_mepc;
    else if (a == 12'h342) v = m_mcause;
    else if (a == 12'hB00) v = CNT_EN ? m_cycle[31:0] : 0;
    else if (a == 12'hB80) v = CNT_EN ? m_cycle[63:32] : 0;
    else if (a == 12'hB02) v = CNT_EN ? m_instret[31:0] : 0;
    else if (a == 12'hB82) v = CNT_EN ? m_instret[63:32] : 0;
    else if (a == 12'hF11) v = 32'h79737978;
    else if (a == 12'hF12) v = 25040129;
    else if (a == 12'hF13 || a == 12'hF14) v = 0;
    else impl = 0;
  endfunction

  task automatic step(input bit r, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input bit tv, input logic [31:0] tc,
                      input logic [31:0] tp, input bit mr, input bit ret);
    logic [31:0] v, nv, base, tgt;
    bit impl, ill, cyc_w, ins_w;
    @(posedge clk);
    #1;
    rst = r; csr_op = op; csr_addr = a; csr_wdata = wd;
    trap_valid = tv; trap_cause = tc; trap_pc = tp; mret = mr; retire = ret;
    model_read(a, v, impl);
    ill = (op != 0) && (!impl || a[11:10] == 2'b11);
    if (armed) rd_q.push_back('{cyc, ovr_en ? ovr_val : v, ill, m_mie});
    ovr_en = 0;
    cyc_w = 0;
    ins_w = 0;
    if (r) begin
      m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 11;
      m_cycle = 0; m_instret = 0;
    end else begin
      if (tv) begin
        base = m_mtvec - (m_mtvec % 4);
        if (m_mtvec[0] == 1'b1 && tc[31] == 1'b1) tgt = base + (tc % 32'h8000_0000) * 4;
        else tgt = base;
        redir_q.push_back('{cyc + 1, tgt});
        m_mepc = tp - (tp % 4);
        m_mcause = tc;
        m_mpie = m_mie;
        m_mie = 0;
      end else if (mr) begin
        redir_q.push_back('{cyc + 1, m_mepc});
        m_mie = m_mpie;
        m_mpie = 1;
      end else if (op != 0 && !ill) begin
        nv = (op == 1) ? wd : (op == 2) ? (v | wd) : (v & ~wd);
        if (a == 12'h300) begin m_mie = nv[3]; m_mpie = nv[7]; end
        else if (a == 12'h305) m_mtvec = nv & ~32'd2;
        else if (a == 12'h340) m_mscratch = nv;
        else if (a == 12'h341) m_mepc = nv & ~32'd3;
        else if (a == 12'h342) m_mcause = nv;
        else if (a == 12'hB00) begin m_cycle[31:0] = nv;    cyc_w = 1; end
        else if (a == 12'hB80) begin m_cycle[63:32] = nv;   cyc_w = 1; end
        else if (a == 12'hB02) begin m_instret[31:0] = nv;  ins_w = 1; end
        else if (a == 12'hB82) begin m_instret[63:32] = nv; ins_w = 1; end
      end
      if (!cyc_w) m_cycle = m_cycle + 1;
      if (!ins_w && ret) m_instret = m_instret + 1;
    end
    cyc++;
  endtask

  task automatic rd_exp(input logic [11:0] a, input logic [31:0] e);
    ovr_en = 1;
    ovr_val = e;
    step(0, 2'b00, a, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 2'b00, 12'h000, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every cycle once the bench is armed.
  always @(negedge clk) begin
    rd_item_t    it;
    redir_item_t ri;
    int t;
    if (armed) begin
      t = cyc - 1;
      if (rd_q.size() > 0 && rd_q[0].tag == t) begin
        it = rd_q.pop_front();
        chk("csr_rdata", 64'(csr_rdata), 64'(it.rdata));
        chk("csr_illegal", 64'(csr_illegal), 64'(it.illegal));
        chk("mstatus_mie", 64'(mstatus_mie), 64'(it.mie));
      end
      if (redir_q.size() > 0 && redir_q[0].due == t) begin
        ri = redir_q.pop_front();
        chk("redirect_valid", 64'(redirect_valid), 64'd1);
        chk("redirect_pc", 64'(redirect_pc), 64'(ri.pc));
      end else begin
        chk("redirect_idle", 64'(redirect_valid), 64'd0);
      end
    end
  end

  logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12,
                            12'hF14, 12'h7C0, 12'h344, 12'hB01};

  initial begin
    logic [31:0] tc;
    rst = 1; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; mret = 0; retire = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    armed = 1;

    // reset values
    rd_exp(12'h300, 32'h1800);
    rd_exp(12'h342, 32'd11);
    rd_exp(12'hF11, 32'h79737978);
    rd_exp(12'hF12, 32'd25040129);
    rd_exp(12'h305, 32'h0);

    // vectored interrupt trap
    step(0, 2'b01, 12'h305, 32'h80000003, 0, 0, 0, 0, 0);
    rd_exp(12'h305, 32'h80000001);
    step(0, 2'b00, 12'h300, 0, 1, 32'h80000007, 32'h80000106, 0, 0);
    rd_exp(12'h341, 32'h80000104);
    rd_exp(12'h342, 32'h80000007);
    rd_exp(12'h300, 32'h1800);

    // MIE round trip through trap and mret
    step(0, 2'b10, 12'h300, 32'h8, 0, 0, 0, 0, 0);
    rd_exp(12'h300, 32'h1808);
    step(0, 2'b00, 12'h300, 0, 1, 32'h0000000B, 32'h00001230, 0, 0);
    rd_exp(12'h300, 32'h1880);
    step(0, 2'b00, 12'h300, 0, 0, 0, 0, 1, 0);
    rd_exp(12'h300, 32'h1888);
    // trap + mret + csr write together: trap only
    step(0, 2'b01, 12'h340, 32'hDEADBEEF, 1, 32'h00000002, 32'h00002000, 1, 0);
    rd_exp(12'h340, 32'h0);
    rd_exp(12'h300, 32'h1880);
    rd_exp(12'h341, 32'h00002000);

    // illegal accesses
    step(0, 2'b11, 12'hF11, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    rd_exp(12'hF11, 32'h79737978);
    rd_exp(12'h7C0, 32'h0);
    step(0, 2'b01, 12'h7C0, 32'h5, 0, 0, 0, 0, 0);

    // counters
    step(0, 2'b01, 12'hB00, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    step(0, 2'b01, 12'hB80, 32'h0, 0, 0, 0, 0, 0);
    rd_exp(12'hB80, 32'h0);
    rd_exp(12'hB80, CNT_EN ? 32'h1 : 32'h0);
    idle();
    step(0, 2'b01, 12'hB02, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 2'b00, 12'h000, 0, 0, 0, 0, 0, 1);
    rd_exp(12'hB02, CNT_EN ? 32'h5 : 32'h0);
    step(0, 2'b01, 12'hB00, 32'h5, 0, 0, 0, 0, 0);
    idle();

    // reset mid-sequence cancels a same-cycle trap redirect
    step(0, 2'b00, 12'h000, 0, 1, 32'h3, 32'h100, 0, 0);
    step(1, 2'b00, 12'h000, 0, 1, 32'h3, 32'h100, 0, 0);
    rd_exp(12'h300, 32'h1800);
    rd_exp(12'h341, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tc = $urandom;
      if ($urandom_range(0, 1) == 0) tc = {tc[31], 26'd0, tc[4:0]};
      step(($urandom_range(0, 299) == 0),
           2'($urandom_range(0, 3)),
           pool[$urandom_range(0, 15)],
           $urandom,
           ($urandom_range(0, 15) == 0), tc, $urandom,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    chk("redir_queue_drained", 64'(redir_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_csr_trap.md
# ysyx_25040129_csr_trap

Parametrised machine-mode CSR file with integrated trap entry, `mret` return and 64-bit performance counters. It replaces the flat four-register CSR store in the ysyx_25040129 core: the execute stage drives Zicsr read-modify-write operations, and the write-back stage reports traps, `mret` and retirement. The block returns a registered PC redirect to fetch.

## Interface
- `XLEN`, 32: register width. Legal values are 32 and 64.
- `VENDOR_ID`, 32'h79737978: value of `mvendorid`.
- `ARCH_ID`, 25040129: value of `marchid`.
- `MTVEC_RST`, 0: reset value of `mtvec`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `csr_op` in 2: 00 none, 01 write, 10 set, 11 clear.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: rs1 or zimm operand.
- `csr_rdata` out XLEN: combinational old value at `csr_addr`.
- `csr_illegal` out 1: combinational flag; the access is illegal.
- `trap_valid` in 1: trap-entry pulse.
- `trap_cause` in XLEN: mcause value; the MSB is the interrupt flag.
- `trap_pc` in XLEN: faulting PC.
- `mret` in 1: `mret` retire pulse.
- `retire` in 1: one instruction retired this cycle.
- `redirect_valid` out 1: registered one-cycle redirect pulse.
- `redirect_pc` out XLEN: registered redirect target.
- `mstatus_mie` out 1: current MIE bit.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300. Only MIE[3], MPIE[7] and MPP[12:11] are writable. MPP is WARL and always reads 2'b11.
  - `misa` 0x301. Read-only constant: MXL per XLEN, I set, M set.
  - `mtvec` 0x305. Bit 1 is forced to 0. Bit 0 selects the mode: 0 direct, 1 vectored.
  - `mscratch` 0x340.
  - `mepc` 0x341. Bits [1:0] are forced to 0.
  - `mcause` 0x342.
  - `mcycle` 0xB00 and `minstret` 0xB02.
  - `mcycleh` 0xB80 and `minstreth` 0xB82. These exist only when XLEN=32.
  - `mvendorid`, `marchid`, `mimpid` (reads 0) and `mhartid` (reads 0) at 0xF11 to 0xF14.
- Write data by `csr_op`: write gives wdata; set gives old|wdata; clear gives old&~wdata.
- `csr_illegal` is 1 when `csr_op`≠00 and either condition holds:
  - the address is unimplemented;
  - `csr_addr[11:10]`=2'b11 (read-only space).
- An illegal access modifies no state. `csr_rdata` reads 0 for unimplemented addresses.
- Trap entry when `trap_valid`=1:
  - `mepc` ← `trap_pc` with bits [1:0] cleared.
  - `mcause` ← `trap_cause`.
  - MPIE ← MIE, then MIE ← 0, and MPP ← 11.
  - Redirect target in direct mode: `mtvec` with bits [1:0] cleared.
  - Redirect target in vectored mode with an interrupt cause: base + 4×`trap_cause[XLEN-2:0]`, truncated to XLEN.
  - Redirect target in vectored mode with an exception cause: base.
- `mret`: MIE ← MPIE, MPIE ← 1, MPP ← 11. Redirect target is `mepc`.
- Counters:
  - `mcycle` increments every non-reset cycle.
  - `minstret` increments when `retire`=1.
  - Both are 64-bit and wrap from all-ones to 0.

## Timing
- Reset values after `rst`:
  - `mstatus` = 0x1800, `mtvec` = `MTVEC_RST`, `mcause` = 11.
  - `mepc`, `mscratch` and both counters = 0.
  - `redirect_valid` = 0, `redirect_pc` = 0, `mstatus_mie` = 0.
- A `rst` pulse mid-sequence cancels any redirect pending for the next cycle.
- CSR writes, trap and `mret` updates commit at the next rising edge.
- `csr_rdata` always shows the pre-edge value.
- `redirect_valid` and `redirect_pc` assert exactly one cycle after `trap_valid` or `mret`, for one cycle.
- The redirect target uses the `mtvec` or `mepc` value before the edge.
- Same-cycle priority is trap > `mret` > `csr_op`. The loser has no effect.
- A CSR write to a counter in the same cycle as its increment: the write wins for the written half. The other half holds, with no carry that cycle.
- A carry from the low to the high half takes effect in the same cycle as the low-half wrap.
- `retire` and `trap_valid` in the same cycle: `minstret` still increments.

## Configuration
- `YSYX_25040129_CSR_COUNTER_EN` defined: `mcycle`, `minstret` and, for XLEN=32, their high halves are implemented as specified above.
- Macro undefined:
  - No counter flops are synthesised.
  - Counter addresses read 0.
  - Counter writes are ignored but do not set `csr_illegal`.

## Test plan
- Reset, then read 0x300, 0x342, 0xF11 and 0xF12 → 0x1800, 11, 0x79737978 and 25040129 respectively.
- Write 0x305 ← 0x80000003, then trap with cause 0x80000007 and pc 0x80000106:
  - next cycle `redirect_pc` = 0x8000001C;
  - `mepc` = 0x80000104;
  - MIE = 0 and MPIE equals the old MIE.
- Set MIE (op 10, wdata 0x8), trap, then `mret` → MIE returns to 1 and `redirect_pc` = `mepc`. Apply trap and `mret` in the same cycle → trap semantics only.
- Clear on 0xF11 → `csr_illegal`=1 and no state changes. Op 00 at 0x7C0 → `csr_illegal`=0 and `csr_rdata`=0.
- With the macro on, write `mcycle` ← 0xFFFFFFFF and `mcycleh` ← 0 → two cycles later `mcycleh`=1 and `mcycle`=0. Hold `retire` for 5 cycles → `minstret`=5.
- With the macro off, write 0xB00 ← 5 → reads 0 and `csr_illegal`=0.
